// File: rtl/fphub_sqrt_sched.sv
// Round-robin scheduler sharing one iterative FPHUB square-root core among NREQ requesters.
// Special operands bypass the core; a watchdog bounds the wait for the core's finish.
module fphub_sqrt_sched #(
  parameter int E    = 8,
  parameter int M    = 23,
  parameter int NREQ = 4,
  parameter int N    = 31,
  localparam int W   = E + M + 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*W-1:0]     req_x,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [W-1:0]          resp_res,
  output logic                  resp_err,
  output logic                  core_start,
  output logic [W-1:0]          core_x,
  input  logic [W-1:0]          core_res,
  input  logic                  core_finish,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(N + 5);
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, grant, id;
  logic           found;
  int             idx;
  logic [W-1:0]   x, res, gx, special_res;
  logic           err, hs, special, timeout;
  logic [CW-1:0]  cnt;
  logic [E-1:0]   g_exp;
  logic [M-1:0]   g_man;
  logic           g_sgn;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign gx      = req_x[grant*W +: W];
  assign hs      = (state == IDLE) && found;
  assign g_sgn   = gx[W-1];
  assign g_exp   = gx[W-2 -: E];
  assign g_man   = gx[M-1:0];
  assign timeout = (cnt == CW'(N + 3));

  // Zeros and +inf pass through; NaNs and negative nonzero operands give canonical NaN.
  always_comb begin
    special     = 1'b1;
    special_res = gx;
    if (g_exp == '0)
      special_res = gx;
    else if ((&g_exp) && (g_man == '0) && !g_sgn)
      special_res = gx;
    else if ((&g_exp) || g_sgn)
      special_res = QNAN;
    else
      special = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = special ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (core_finish || timeout) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = hs ? (NREQ'(1) << grant) : '0;
    resp_valid = (state == RESP);
    core_start = (state == ISSUE);
    busy       = (state != IDLE);
    resp_id    = id;
    resp_res   = res;
    resp_err   = err;
    core_x     = x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      id  <= '0;
      x   <= '0;
      res <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          x   <= gx;
          id  <= grant;
          ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
          err <= 1'b0;
          if (special) res <= special_res;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // finish has priority over a watchdog expiry in the same cycle
          if (core_finish) begin
            res <= core_res;
            err <= 1'b0;
          end else if (timeout) begin
            res <= QNAN;
            err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fphub_sqrt_sched.sv
// Bench for fphub_sqrt_sched: scoreboard of expected responses filled at each grant,
// checked when the response handshake occurs; per-scenario tasks check timing and flow control.
module tb_fphub_sqrt_sched;
  localparam int E = 8, M = 23, NREQ = 4, N = 31;
  localparam int W = E + M + 1, IDW = 2;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_x;
  logic              resp_valid, resp_ready, resp_err;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_res, core_x, core_res;
  logic              core_start, core_finish, busy;

  fphub_sqrt_sched #(.E(E), .M(M), .NREQ(NREQ), .N(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_res(resp_res), .resp_err(resp_err), .core_start(core_start),
    .core_x(core_x), .core_res(core_res), .core_finish(core_finish), .busy(busy)
  );

  int checks = 0, failures = 0;
  int cyc = 0, starts = 0, start_cyc = -1, rv_rise_cyc = -1, resp_cnt = 0;
  logic [31:0] last_res;
  logic        last_err;
  logic [1:0]  last_id;
  logic        prev_rv = 1'b0;
  bit          core_en = 1'b1;
  int          glog[$], gcyc[$];
  logic [34:0] sb[$];
  int          cd = 0;
  bit          pend = 1'b0;

  // Stand-in core: 4.0 -> 2.0, any other operand -> a fixed scramble of it.
  function automatic logic [31:0] core_fn(input logic [31:0] v);
    return (v == 32'h40800000) ? 32'h40000000 : (v ^ 32'h00F00F00);
  endfunction

  function automatic logic [32:0] model(input logic [31:0] v, input bit en);
    logic [7:0] ex;
    ex = v[30:23];
    if (ex == 8'h00)                               return {v, 1'b0};
    if (ex == 8'hFF && v[22:0] == 23'd0 && !v[31]) return {v, 1'b0};
    if (ex == 8'hFF || v[31])                      return {QNAN, 1'b0};
    if (en)                                        return {core_fn(v), 1'b0};
    return {QNAN, 1'b1};
  endfunction

  assign core_res = core_fn(core_x);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Core model: finish pulse sampled N+1 cycles after the start cycle.
  always @(negedge clk) begin
    core_finish = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin core_finish = 1'b1; pend = 1'b0; end
    end
    if (core_start && core_en && !rst) begin pend = 1'b1; cd = N + 1; end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (core_start) begin starts++; start_cyc = cyc; end
      if (resp_valid && !prev_rv) rv_rise_cyc = cyc;
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          glog.push_back(i);
          gcyc.push_back(cyc);
          sb.push_back({2'(i), model(req_x[i*W +: W], core_en)});
        end
      if (resp_valid && resp_ready) begin
        logic [34:0] e;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got id=%0d res=%h err=%0d, required no response", resp_id, resp_res, resp_err);
        end else begin
          e = sb.pop_front();
          if ({resp_id, resp_res, resp_err} !== e) begin
            failures++;
            $display("FAIL scoreboard: got id=%0d res=%h err=%0d, required id=%0d res=%h err=%0d",
                     resp_id, resp_res, resp_err, e[34:33], e[32:1], e[0]);
          end
        end
        last_id = resp_id; last_res = resp_res; last_err = resp_err;
        resp_cnt++;
      end
    end
    prev_rv = resp_valid;
  end

  task automatic wait_resps(input int n, input int bound, input string nm);
    int t = 0;
    while (resp_cnt < n && t < bound) begin @(posedge clk); #1; t++; end
    checks++;
    if (resp_cnt < n) begin
      failures++;
      $display("FAIL %s_timeout: responses=%0d required=%0d", nm, resp_cnt, n);
    end
  endtask

  task automatic send(input int i, input logic [31:0] v, output int hs);
    int g0 = glog.size();
    int t = 0;
    req_x[i*W +: W] = v;
    req_valid[i] = 1'b1;
    while (glog.size() == g0 && t < 200) begin @(posedge clk); #1; t++; end
    req_valid[i] = 1'b0;
    checks++;
    if (glog.size() == g0) begin
      failures++; hs = -1;
      $display("FAIL grant_timeout: requester %0d not granted, required grant", i);
    end else hs = gcyc[g0];
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 8;
    if (req_ready !== 4'b0)   begin failures++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
    if (resp_valid !== 1'b0)  begin failures++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    if (resp_id !== 2'd0)     begin failures++; $display("FAIL rst_resp_id: got %0d required 0", resp_id); end
    if (resp_res !== 32'd0)   begin failures++; $display("FAIL rst_resp_res: got %h required 0", resp_res); end
    if (resp_err !== 1'b0)    begin failures++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
    if (core_start !== 1'b0)  begin failures++; $display("FAIL rst_core_start: got %b required 0", core_start); end
    if (core_x !== 32'd0)     begin failures++; $display("FAIL rst_core_x: got %h required 0", core_x); end
    if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single;
    int hs, s0 = starts, r0 = resp_cnt;
    core_en = 1'b1; resp_ready = 1'b1;
    send(2, 32'h40800000, hs);
    wait_resps(r0 + 1, 100, "single");
    repeat (3) @(posedge clk); #1;
    checks += 6;
    if (starts - s0 !== 1)        begin failures++; $display("FAIL single_starts: got %0d required 1", starts - s0); end
    if (start_cyc !== hs + 1)     begin failures++; $display("FAIL single_start_cyc: got %0d required %0d", start_cyc, hs + 1); end
    if (rv_rise_cyc !== hs + N + 3) begin failures++; $display("FAIL single_latency: got %0d required %0d", rv_rise_cyc, hs + N + 3); end
    if (last_id !== 2'd2)         begin failures++; $display("FAIL single_id: got %0d required 2", last_id); end
    if (last_res !== 32'h40000000) begin failures++; $display("FAIL single_res: got %h required 40000000", last_res); end
    if (last_err !== 1'b0)        begin failures++; $display("FAIL single_err: got %b required 0", last_err); end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    int g0, t = 0, r0;
    rst = 1'b1; sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    r0 = resp_cnt; g0 = glog.size();
    for (int i = 0; i < NREQ; i++) req_x[i*W +: W] = 32'h41000000 | i;
    req_valid = '1;
    while (glog.size() < g0 + 5 && t < 1000) begin @(posedge clk); #1; t++; end
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (glog.size() <= g0 + k) begin
        failures++; $display("FAIL rr_grant%0d: no grant, required %0d", k, order[k]);
      end else if (glog[g0 + k] !== order[k]) begin
        failures++; $display("FAIL rr_grant%0d: got %0d required %0d", k, glog[g0 + k], order[k]);
      end
    end
    wait_resps(r0 + 5, 300, "rr");
  endtask

  task automatic test_special;
    logic [31:0] ops[4]  = '{32'h80000000, 32'h7F800000, 32'hBF800000, 32'h7F800001};
    logic [31:0] want[4] = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000};
    int hs, s0, r0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s0 = starts; r0 = resp_cnt;
      send(1, ops[k], hs);
      wait_resps(r0 + 1, 20, "special");
      checks += 3;
      if (rv_rise_cyc !== hs + 1) begin failures++; $display("FAIL special%0d_latency: got %0d required %0d", k, rv_rise_cyc, hs + 1); end
      if (last_res !== want[k])   begin failures++; $display("FAIL special%0d_res: got %h required %h", k, last_res, want[k]); end
      if (starts !== s0)          begin failures++; $display("FAIL special%0d_start: got %0d starts required 0", k, starts - s0); end
    end
  endtask

  task automatic test_watchdog;
    int hs, r0 = resp_cnt;
    core_en = 1'b0; resp_ready = 1'b1;
    send(3, 32'h40400000, hs);
    wait_resps(r0 + 1, 100, "wdog");
    checks += 3;
    if (rv_rise_cyc !== hs + 37)  begin failures++; $display("FAIL wdog_latency: got %0d required %0d", rv_rise_cyc, hs + 37); end
    if (last_err !== 1'b1)        begin failures++; $display("FAIL wdog_err: got %b required 1", last_err); end
    if (last_res !== QNAN)        begin failures++; $display("FAIL wdog_res: got %h required %h", last_res, QNAN); end
    core_en = 1'b1;
    send(3, 32'h40800000, hs);
    wait_resps(r0 + 2, 100, "wdog_next");
    checks += 2;
    if (last_err !== 1'b0 || last_res !== 32'h40000000) begin
      failures++; $display("FAIL wdog_next: got res=%h err=%b required res=40000000 err=0", last_res, last_err);
    end
    if (rv_rise_cyc !== hs + N + 3) begin failures++; $display("FAIL wdog_next_latency: got %0d required %0d", rv_rise_cyc, hs + N + 3); end
  endtask

  task automatic test_back_to_back;
    int g0 = glog.size(), t = 0, r0 = resp_cnt;
    resp_ready = 1'b1;
    req_x[1*W +: W] = 32'h00000000;
    req_valid[1] = 1'b1;
    while (glog.size() < g0 + 2 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = '0;
    checks++;
    if (glog.size() < g0 + 2) begin
      failures++; $display("FAIL b2b_grants: got %0d grants required 2", glog.size() - g0);
    end else if (gcyc[g0 + 1] - gcyc[g0] !== 2) begin
      failures++; $display("FAIL b2b_spacing: got %0d cycles required 2", gcyc[g0 + 1] - gcyc[g0]);
    end
    wait_resps(r0 + 2, 20, "b2b");
  endtask

  task automatic test_backpressure;
    int hs, t = 0, r0 = resp_cnt;
    resp_ready = 1'b0;
    send(0, 32'h40800000, hs);
    while (!resp_valid && t < 100) begin @(posedge clk); #1; t++; end
    req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_res !== 32'h40000000 || resp_err !== 1'b0 ||
          req_ready !== 4'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d res=%h err=%b rdy=%b busy=%b required v=1 id=0 res=40000000 err=0 rdy=0 busy=1",
                 k, resp_valid, resp_id, resp_res, resp_err, req_ready, busy);
      end
    end
    @(posedge clk); #1;
    req_valid = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_cnt !== r0 + 1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release: got responses=%0d valid=%b required responses=%0d valid=0", resp_cnt - r0, resp_valid, 1);
    end
  endtask

  task automatic test_reset_mid;
    int hs, r0, g0, t = 0;
    core_en = 1'b1; resp_ready = 1'b1;
    send(1, 32'h40800000, hs);
    repeat (5) @(posedge clk); #1;
    rst = 1'b1; sb.delete();
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_res, resp_err, core_start, core_x, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got rdy=%b v=%b id=%0d res=%h err=%b start=%b x=%h busy=%b required all 0",
               req_ready, resp_valid, resp_id, resp_res, resp_err, core_start, core_x, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    r0 = resp_cnt;
    repeat (40) @(posedge clk); #1;
    checks += 2;
    if (resp_cnt !== r0) begin failures++; $display("FAIL midrst_stray: got %0d responses required 0", resp_cnt - r0); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    g0 = glog.size();
    req_x[3*W +: W] = 32'h40800000; req_x[0*W +: W] = 32'h40800000;
    req_valid = 4'b1001;
    while (glog.size() == g0 && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = '0;
    checks++;
    if (glog.size() == g0 || glog[g0] !== 0) begin
      failures++; $display("FAIL midrst_grant: got %0d required 0", (glog.size() == g0) ? -1 : glog[g0]);
    end
    wait_resps(r0 + 1, 100, "midrst");
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; resp_ready = 1'b0; core_finish = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_special();
    test_watchdog();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
